// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word and RAM handshake types, plus the memory arbiter's grant states.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} arb_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counts enabled cycles and holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_cnt <= '0;
        else if (i_en && !(&r_cnt)) r_cnt <= r_cnt + W'(1);
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises instruction and data requests onto one RAM port.
// The data side has priority, grants are registered and never pre-empted.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iREN,
    input  word_t            iaddr,
    input  logic             dREN,
    input  logic             dWEN,
    input  word_t            daddr,
    input  word_t            dstore,
    output logic             iwait,
    output logic             dwait,
    output word_t            iload,
    output word_t            dload,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  ramstate_t        ramstate,
    output logic             err,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    arb_state_t r_state, w_next;
    logic [TW-1:0] r_timer;
    logic r_err, w_set_err, w_dreq, w_own_req, w_tmo;
    always_comb begin
        w_dreq    = dREN | dWEN;
        w_own_req = (r_state == I_ACC) ? iREN : w_dreq;
        w_tmo     = r_timer == TW'(TIMEOUT);
        w_next    = r_state;
        w_set_err = 1'b0;
        if (r_state == IDLE) w_next = w_dreq ? D_ACC : (iREN ? I_ACC : IDLE);
        else if (!w_own_req || ramstate == ACCESS) w_next = IDLE;
        else if (ramstate == ERROR || w_tmo) begin
            w_next    = IDLE;
            w_set_err = 1'b1;
        end
        ramREN   = (r_state == I_ACC) || (r_state == D_ACC && dREN && !dWEN);
        ramWEN   = (r_state == D_ACC) && dWEN;
        ramaddr  = (r_state == I_ACC) ? iaddr : ((r_state == D_ACC) ? daddr : '0);
        ramstore = (r_state == D_ACC) ? dstore : '0;
        iwait    = iREN && !(r_state == I_ACC && ramstate == ACCESS);
        dwait    = w_dreq && !(r_state == D_ACC && ramstate == ACCESS);
    end
    // Every ACC state is entered from IDLE, so clearing in IDLE clears on entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= (r_state == IDLE) ? '0 : (w_tmo ? r_timer : r_timer + TW'(1));
            r_err   <= r_err | w_set_err;
        end
    end
    assign err   = r_err;
    assign iload = ramload;
    assign dload = ramload;
    sat_counter #(.W(CNT_W)) u_istall (.i_clk(CLK), .i_rst(RST), .i_en(iwait), .o_cnt(istall_cnt));
    sat_counter #(.W(CNT_W)) u_dstall (.i_clk(CLK), .i_rst(RST), .i_en(dwait), .o_cnt(dstall_cnt));
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vector table, corner-case sequences and random traffic vs a reference model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    logic CLK = 1'b0;
    logic RST, iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, err;
    word_t iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic [CW-1:0] istall_cnt, dstall_cnt;
    always #5 CLK = ~CLK;
    memory_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .err(err),
        .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
    );
    typedef struct {
        logic rst, ir, dr, dw;
        word_t ia, da, ds, rl;
        logic [1:0] rs;
        logic chk;
        logic iw, dwo, rren, rwen;
        word_t raddr;
        logic er;
    } vec_t;
    // Reference model: owner 0 = nobody, 1 = instruction side, 2 = data side.
    int m_own = 0, m_t = 0, m_ic = 0, m_dc = 0;
    logic m_err = 1'b0;
    int checks = 0, errors = 0, row = 0;
    vec_t tbl[22];
    function automatic vec_t mk(logic rst, logic ir, logic dr, logic dw, word_t ia, word_t da,
                                word_t ds, logic [1:0] rs, word_t rl, logic iw, logic dwo,
                                logic rren, logic rwen, word_t raddr, logic er);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds;
        v.rs = rs; v.rl = rl; v.chk = 1'b1; v.iw = iw; v.dwo = dwo; v.rren = rren;
        v.rwen = rwen; v.raddr = raddr; v.er = er;
        return v;
    endfunction
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h exp %h", name, row, got, exp);
        end
    endtask
    task automatic apply(vec_t v);
        logic dreq, acc, e_iw, e_dw, e_rren, e_rwen, req;
        word_t e_addr, e_st;
        @(negedge CLK);
        RST = v.rst; iREN = v.ir; dREN = v.dr; dWEN = v.dw; iaddr = v.ia; daddr = v.da;
        dstore = v.ds; ramload = v.rl; ramstate = ramstate_t'(v.rs);
        #1;
        dreq   = v.dr | v.dw;
        acc    = v.rs == 2'd2;
        e_iw   = v.ir && !(m_own == 1 && acc);
        e_dw   = dreq && !(m_own == 2 && acc);
        e_rren = (m_own == 1) || (m_own == 2 && v.dr && !v.dw);
        e_rwen = (m_own == 2) && v.dw;
        e_addr = (m_own == 1) ? v.ia : ((m_own == 2) ? v.da : 32'h0);
        e_st   = (m_own == 2) ? v.ds : 32'h0;
        chk("iwait", 32'(iwait), 32'(e_iw));
        chk("dwait", 32'(dwait), 32'(e_dw));
        chk("ramREN", 32'(ramREN), 32'(e_rren));
        chk("ramWEN", 32'(ramWEN), 32'(e_rwen));
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_st);
        chk("iload", iload, v.rl);
        chk("dload", dload, v.rl);
        chk("err", 32'(err), 32'(m_err));
        chk("istall_cnt", 32'(istall_cnt), 32'(m_ic));
        chk("dstall_cnt", 32'(dstall_cnt), 32'(m_dc));
        if (v.chk) begin
            chk("vec_iwait", 32'(iwait), 32'(v.iw));
            chk("vec_dwait", 32'(dwait), 32'(v.dwo));
            chk("vec_ramREN", 32'(ramREN), 32'(v.rren));
            chk("vec_ramWEN", 32'(ramWEN), 32'(v.rwen));
            chk("vec_ramaddr", ramaddr, v.raddr);
            chk("vec_err", 32'(err), 32'(v.er));
        end
        @(posedge CLK);
        if (v.rst) begin
            m_own = 0; m_t = 0; m_err = 1'b0; m_ic = 0; m_dc = 0;
        end else begin
            m_ic = (m_ic + int'(e_iw) > CMAX) ? CMAX : m_ic + int'(e_iw);
            m_dc = (m_dc + int'(e_dw) > CMAX) ? CMAX : m_dc + int'(e_dw);
            if (m_own == 0) begin
                m_own = dreq ? 2 : (v.ir ? 1 : 0);
                m_t = 0;
            end else begin
                req = (m_own == 1) ? v.ir : dreq;
                if (!req || acc) m_own = 0;
                else if (v.rs == 2'd3 || m_t == TO) begin
                    m_own = 0;
                    m_err = 1'b1;
                end else m_t = m_t + 1;
            end
        end
        row++;
    endtask
    initial begin
        vec_t v;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; iaddr = '0; daddr = '0;
        dstore = '0; ramload = '0; ramstate = FREE;
        @(posedge CLK);
        tbl[0]  = mk(1, 1, 0, 0, 32'h40, 0, 0, FREE, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 32'h40, 0, 0, FREE, 0, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 32'h40, 0, 0, ACCESS, 32'h2402000A, 0, 0, 1, 0, 32'h40, 0);
        tbl[3]  = mk(0, 1, 0, 1, 32'h44, 32'h80, 32'hDEAD, ACCESS, 0, 1, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 1, 32'h44, 32'h80, 32'hDEAD, ACCESS, 0, 1, 0, 0, 1, 32'h80, 0);
        tbl[5]  = mk(0, 1, 0, 0, 32'h44, 32'h80, 32'hDEAD, ACCESS, 0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 32'h44, 0, 0, ACCESS, 0, 0, 0, 1, 0, 32'h44, 0);
        tbl[7]  = mk(0, 1, 0, 0, 32'h48, 0, 0, BUSY, 0, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 1, 0, 32'h48, 32'h90, 0, BUSY, 0, 1, 1, 1, 0, 32'h48, 0);
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = mk(0, 1, 1, 0, 32'h48, 32'h90, 0, ACCESS, 0, 0, 1, 1, 0, 32'h48, 0);
        tbl[12] = mk(0, 0, 1, 0, 32'h48, 32'h90, 0, BUSY, 0, 0, 1, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 32'h48, 32'h90, 0, ACCESS, 0, 0, 0, 1, 0, 32'h90, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, 32'hA0, 0, BUSY, 0, 0, 1, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 1, 0, 0, 32'hA0, 0, BUSY, 0, 0, 1, 1, 0, 32'hA0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 32'hA0, 0, BUSY, 0, 0, 0, 0, 0, 32'hA0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 1, 0, 0, 32'h4C, 0, 0, BUSY, 0, 1, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 1, 0, 0, 32'h4C, 0, 0, BUSY, 0, 1, 0, 1, 0, 32'h4C, 0);
        tbl[20] = mk(0, 1, 0, 0, 32'h4C, 0, 0, BUSY, 0, 1, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 1, 0, 0, 32'h4C, 0, 0, ACCESS, 0, 0, 0, 1, 0, 32'h4C, 0);
        for (int i = 0; i < 22; i++) apply(tbl[i]);
        // Timeout: TIMEOUT+1 cycles in I_ACC, then one IDLE cycle with err set, then regrant.
        for (int k = 0; k < 8; k++) begin
            logic g;
            g = (k >= 1 && k <= 5) || k == 7;
            apply(mk(0, 1, 0, 0, 32'h50, 0, 0, BUSY, 0, 1, 0, g, 0, g ? 32'h50 : 32'h0, k >= 6));
        end
        v = mk(1, 0, 0, 0, 0, 0, 0, FREE, 0, 0, 0, 0, 0, 0, 0);
        v.chk = 1'b0;
        apply(v);
        apply(mk(0, 1, 0, 0, 32'h54, 0, 0, ERROR, 0, 1, 0, 0, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 32'h54, 0, 0, ERROR, 0, 1, 0, 1, 0, 32'h54, 0));
        apply(mk(0, 1, 0, 0, 32'h54, 0, 0, ERROR, 0, 1, 0, 0, 0, 0, 1));
        apply(v);
        for (int k = 0; k < 20; k++) begin
            vec_t s;
            s = mk(0, 1, 0, 0, 32'h58, 0, 0, BUSY, 0, 0, 0, 0, 0, 0, 0);
            s.chk = 1'b0;
            apply(s);
        end
        @(negedge CLK);
        chk("istall_saturated", 32'(istall_cnt), 32'(CMAX));
        for (int k = 0; k < 500; k++) begin
            vec_t r;
            r = mk($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom,
                   $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom,
                   0, 0, 0, 0, 0, 0);
            r.chk = 1'b0;
            apply(r);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
